// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and its refill engine:
// default geometry and the refill FSM state encoding.
package cache_pkg;

    localparam int CACHE_ADDR_W     = 7;
    localparam int CACHE_DATA_W     = 8;
    localparam int CACHE_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        FIN,
        ERR
    } refill_state_e;

endpackage

// File: rtl/refill_watchdog.sv
// Counts consecutive cycles a memory access waits without an acknowledge and
// flags expiry in the cycle the wait reaches TIMEOUT.
module refill_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic clr,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is seen during the TIMEOUT-th waiting cycle, so the FSM leaves
    // on that edge and the request never waits longer than TIMEOUT cycles.
    assign expired = active && !ack && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr || expired || (active && ack)) begin
            count_d = '0;
        end else if (active) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cache_refill_engine.sv
// Miss-service engine: optional victim writeback, then a word-by-word line
// fetch streamed into the cache data array, abandoned on a memory timeout.
module cache_refill_engine
    import cache_pkg::*;
#(
    parameter int ADDR_W     = CACHE_ADDR_W,
    parameter int DATA_W     = CACHE_DATA_W,
    parameter int LINE_WORDS = CACHE_LINE_WORDS,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_dirty,
    input  logic [ADDR_W-1:0]             req_victim_addr,
    output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
    input  logic [DATA_W-1:0]             wb_data,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          fill_valid,
    output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
    output logic [DATA_W-1:0]             fill_data,
    output logic                          done,
    output logic                          err
);
    localparam int                IDX_W     = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    refill_state_e     state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] miss_base_q, miss_base_d;
    logic [ADDR_W-1:0] vic_base_q, vic_base_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              fill_valid_q, fill_valid_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic ack_ok;
    logic wd_expired;

    // An acknowledge only means something while an access is outstanding.
    assign ack_ok = mem_ack && mem_req_q;

    refill_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (mem_req_q),
        .ack    (ack_ok),
        .clr    (state_q == IDLE),
        .expired(wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        miss_base_d  = miss_base_q;
        vic_base_d   = vic_base_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    miss_base_d = req_addr & BASE_MASK;
                    vic_base_d  = req_victim_addr & BASE_MASK;
                    cnt_d       = '0;
                    state_d     = req_dirty ? WB : RD;
                end
            end
            WB: begin
                if (wd_expired) begin
                    state_d = ERR;
                end else if (ack_ok) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = RD;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            RD: begin
                if (wd_expired) begin
                    state_d = ERR;
                end else if (ack_ok) begin
                    fill_valid_d = 1'b1;
                    fill_idx_d   = cnt_q;
                    fill_data_d  = mem_rdata;
                    cnt_d        = cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM enters that state.
        req_ready_d = (state_d == IDLE);
        mem_req_d   = (state_d == WB) || (state_d == RD);
        mem_we_d    = (state_d == WB);
        mem_addr_d  = '0;
        if (mem_req_d) begin
            mem_addr_d = (mem_we_d ? vic_base_d : miss_base_d) + ADDR_W'(cnt_d);
        end
        done_d = (state_d == FIN);
        err_d  = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            miss_base_q  <= '0;
            vic_base_q   <= '0;
            req_ready_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_base_q  <= miss_base_d;
            vic_base_q   <= vic_base_d;
            req_ready_q  <= req_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // The cache answers wb_idx combinationally, so write data follows the
    // registered word index within the same cycle.
    assign mem_wdata  = mem_we_q ? wb_data : '0;
    assign wb_idx     = cnt_q;
    assign req_ready  = req_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign fill_valid = fill_valid_q;
    assign fill_idx   = fill_idx_q;
    assign fill_data  = fill_data_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Randomized bench for cache_refill_engine: a wait-state memory, a transaction
// log and a line-level reference model of the expected accesses and fills.
module tb_cache_refill_engine;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int LW    = 4;
    localparam int IW    = 2;
    localparam int TO    = 15;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          req_dirty = 1'b0;
    logic [AW-1:0] req_victim_addr = '0;
    logic [IW-1:0] wb_idx;
    logic [DW-1:0] wb_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          done;
    logic          err;

    cache_refill_engine dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_dirty      (req_dirty),
        .req_victim_addr(req_victim_addr),
        .wb_idx         (wb_idx),
        .wb_data        (wb_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .fill_valid     (fill_valid),
        .fill_idx       (fill_idx),
        .fill_data      (fill_data),
        .done           (done),
        .err            (err)
    );

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } acc_t;

    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        int            cyc;
    } fill_t;

    acc_t  accs[$];
    fill_t fills[$];
    logic [DW-1:0] mem [128];
    logic [DW-1:0] wb_base = 8'hA0;
    int    wait_plan [8];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    accept_cnt = 0, accept_cyc = 0;
    int    done_cnt = 0, done_cyc = 0;
    int    err_cnt = 0, err_cyc = 0;
    int    acc_idx = 0, wcnt = 0;
    bit    waiting = 0;
    bit    stray = 0;
    acc_t  held;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Victim line as seen by the cache data array.
    always_comb wb_data = wb_base + DW'(wb_idx);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    // Monitor and backing memory: samples DUT outputs mid-cycle and decides
    // whether to acknowledge the access presented in this cycle.
    initial forever begin
        @(negedge clk);
        if (!rst && req_valid && req_ready) begin
            accept_cnt++;
            accept_cyc = cyc;
            acc_idx    = 0;
        end
        if (fill_valid) fills.push_back('{fill_idx, fill_data, cyc});
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; end
        mem_ack   = 1'b0;
        mem_rdata = DW'($urandom);
        if (mem_req) begin
            if (waiting) begin
                check("stable_we",    mem_we,    held.we);
                check("stable_addr",  mem_addr,  held.addr);
                check("stable_wdata", mem_wdata, held.data);
            end else begin
                waiting = 1;
                wcnt    = 0;
                held    = '{mem_we, mem_addr, mem_wdata, 0};
            end
            if (acc_idx < 8 && wcnt >= wait_plan[acc_idx]) begin
                mem_ack = 1'b1;
                if (!mem_we) mem_rdata = mem[mem_addr];
                held.cyc = cyc;
                accs.push_back(held);
                acc_idx++;
                waiting = 0;
            end else begin
                wcnt++;
            end
        end else begin
            waiting = 0;
            if (stray) begin
                mem_ack = 1'b1;
                stray   = 0;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},  req_ready,  1);
        check({tag, "_mem_req"},    mem_req,    0);
        check({tag, "_mem_we"},     mem_we,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_mem_wdata"},  mem_wdata,  0);
        check({tag, "_fill_valid"}, fill_valid, 0);
        check({tag, "_fill_idx"},   fill_idx,   0);
        check({tag, "_fill_data"},  fill_data,  0);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
        check({tag, "_wb_idx"},     wb_idx,     0);
    endtask

    task automatic wait_accept(output bit got);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            wait_neg();
            got = (accept_cnt > 0);
        end
        check("accept_seen", got, 1);
    endtask

    task automatic wait_end(output bit got);
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            wait_neg();
            got = (done_cnt + err_cnt) > 0;
        end
        check("end_seen", got, 1);
    endtask

    // One miss from request to ready; to_k names the access (in issue order)
    // that the memory never acknowledges, or -1.
    task automatic do_txn(input logic [AW-1:0] maddr, input bit dirty,
                          input logic [AW-1:0] vaddr, input int to_k, input bit hold);
        acc_t          exp_acc[$];
        logic [AW-1:0] mb, vb, a;
        int            t, n_words, exp_end, ack, rd_i, i;
        bit            is_to, wr, got;

        @(posedge clk); #1;
        accs.delete(); fills.delete();
        done_cnt = 0; err_cnt = 0; accept_cnt = 0;
        req_addr = maddr; req_dirty = dirty; req_victim_addr = vaddr; req_valid = 1'b1;
        wait_accept(got);
        if (!hold) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
        wait_end(got);

        mb      = maddr & AW'(~(LW - 1));
        vb      = vaddr & AW'(~(LW - 1));
        n_words = dirty ? 2 * LW : LW;
        t       = accept_cyc + 1;
        is_to   = 0;
        exp_end = 0;
        for (int k = 0; k < n_words; k++) begin
            if (k == to_k) begin
                is_to   = 1;
                exp_end = t + TO;
                break;
            end
            wr  = dirty && (k < LW);
            i   = wr ? k : k - (dirty ? LW : 0);
            a   = (wr ? vb : mb) + AW'(i);
            ack = t + wait_plan[k];
            exp_acc.push_back('{wr, a, wr ? wb_base + DW'(i) : DW'(0), ack});
            t = ack + 1;
        end
        if (!is_to) exp_end = t;

        check("acc_count", accs.size(), exp_acc.size());
        rd_i = 0;
        for (int k = 0; k < exp_acc.size() && k < accs.size(); k++) begin
            check("acc_we",   accs[k].we,   exp_acc[k].we);
            check("acc_addr", accs[k].addr, exp_acc[k].addr);
            check("acc_cyc",  accs[k].cyc,  exp_acc[k].cyc);
            if (exp_acc[k].we) begin
                check("wb_data", accs[k].data, exp_acc[k].data);
            end else begin
                if (rd_i < fills.size()) begin
                    check("fill_idx",  fills[rd_i].idx,  rd_i);
                    check("fill_data", fills[rd_i].data, mem[exp_acc[k].addr]);
                    check("fill_cyc",  fills[rd_i].cyc,  exp_acc[k].cyc + 1);
                end
                rd_i++;
            end
        end
        check("fill_count", fills.size(), rd_i);
        check("done_count", done_cnt, is_to ? 0 : 1);
        check("err_count",  err_cnt,  is_to ? 1 : 0);
        check("end_cycle",  is_to ? err_cyc : done_cyc, exp_end);
        check("busy_at_end", req_ready, 0);
        check("accepts_while_busy", accept_cnt, 1);
        $display("txn maddr=0x%02h dirty=%0d vaddr=0x%02h stall_access=%0d accept=%0d end=%0d",
                 maddr, dirty, vaddr, to_k, accept_cyc, is_to ? err_cyc : done_cyc);

        wait_neg();
        check("ready_after_end", req_ready, 1);
        if (hold) begin
            check("held_req_accepted", accept_cnt, 2);
            accs.delete(); fills.delete();
            done_cnt = 0; err_cnt = 0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            wait_end(got);
            check("held_done",       done_cnt,     1);
            check("held_acc_count",  accs.size(),  n_words);
            check("held_fill_count", fills.size(), LW);
            wait_neg();
            check("held_ready", req_ready, 1);
        end
    endtask

    initial begin
        bit got;
        int n_words, to_k;
        bit dirty;

        foreach (wait_plan[k]) wait_plan[k] = 0;
        for (int a = 0; a < 128; a++) mem[a] = DW'(8'h10 + a);

        repeat (3) @(posedge clk);
        wait_neg();
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean and dirty misses against a zero-wait memory.
        do_txn(7'h0A, 1'b0, 7'h00, -1, 1'b0);
        wb_base = 8'hA0;
        do_txn(7'h04, 1'b1, 7'h44, -1, 1'b0);

        // Three wait cycles on every word.
        foreach (wait_plan[k]) wait_plan[k] = 3;
        do_txn(7'h31, 1'b0, 7'h00, -1, 1'b0);
        wb_base = 8'h5C;
        do_txn(7'h62, 1'b1, 7'h1B, -1, 1'b0);

        // Read word 2 never acknowledged.
        foreach (wait_plan[k]) wait_plan[k] = 0;
        wait_plan[2] = NEVER;
        do_txn(7'h0A, 1'b0, 7'h00, 2, 1'b0);

        // Reset while writeback word 1 is waiting.
        foreach (wait_plan[k]) wait_plan[k] = 0;
        wait_plan[1] = 4;
        @(posedge clk); #1;
        accs.delete(); accept_cnt = 0;
        req_addr = 7'h20; req_dirty = 1'b1; req_victim_addr = 7'h50; req_valid = 1'b1;
        wait_accept(got);
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            wait_neg();
            got = (accs.size() == 1);
        end
        check("rst_first_wb_word", accs.size(), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        wait_neg();
        check("rst_mid_wb_req", mem_req, 1);
        check("rst_mid_wb_idx", wb_idx,  1);
        wait_neg();
        check_reset("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        wait_plan[1] = 0;
        do_txn(7'h20, 1'b1, 7'h50, -1, 1'b0);

        // Stray acknowledge in IDLE, then a request held valid throughout.
        @(posedge clk); #1;
        stray = 1;
        wait_neg();
        wait_neg();
        check("stray_ready",      req_ready,  1);
        check("stray_mem_req",    mem_req,    0);
        check("stray_fill_valid", fill_valid, 0);
        check("stray_done",       done,       0);
        check("stray_err",        err,        0);
        do_txn(7'h3C, 1'b0, 7'h00, -1, 1'b1);

        // Randomized misses with random memory contents and wait states.
        for (int a = 0; a < 128; a++) mem[a] = DW'($urandom);
        for (int n = 0; n < 14; n++) begin
            dirty   = 1'($urandom_range(0, 1));
            n_words = dirty ? 2 * LW : LW;
            foreach (wait_plan[k]) wait_plan[k] = $urandom_range(0, 3);
            to_k = -1;
            if ($urandom_range(0, 3) == 0) begin
                to_k = $urandom_range(0, n_words - 1);
                wait_plan[to_k] = NEVER;
            end
            wb_base = DW'($urandom);
            do_txn(AW'($urandom), dirty, AW'($urandom), to_k, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/cache_refill_engine.md
# cache_refill_engine

Miss-service stage directly downstream of `tt_um_cache_controller`. It accepts one line-miss request at a time, optionally writes back a dirty victim line, then fetches the missing line word by word from the backing memory and streams each word into the cache data array. A watchdog abandons a transaction if the backing memory stops acknowledging.

## Interface

Parameters:
- `ADDR_W`, 7, byte-address width. This matches the 7-bit address field the controller decodes from `ui_in[6:0]`.
- `DATA_W`, 8, word width.
- `LINE_WORDS`, 4, words per line; must be a power of two, at least 2.
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack` on one word; must be at least 1.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: the controller presents a miss.
- `req_ready` out 1: the engine is idle and can accept a miss.
- `req_addr` in ADDR_W: address of the missing line. Low `log2(LINE_WORDS)` bits are ignored.
- `req_dirty` in 1: the victim line must be written back first.
- `req_victim_addr` in ADDR_W: line address of the victim. Low bits are ignored.
- `wb_idx` out log2(LINE_WORDS): index of the victim word the engine is requesting.
- `wb_data` in DATA_W: the cache returns this word combinationally, in the same cycle as `wb_idx`.
- `mem_req` out 1: a backing-memory access is pending.
- `mem_we` out 1: 1 means write, 0 means read.
- `mem_addr` out ADDR_W: word address of the access.
- `mem_wdata` out DATA_W: write data.
- `mem_ack` in 1: single-cycle completion. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: read data.
- `fill_valid` out 1: a fill word is present this cycle.
- `fill_idx` out log2(LINE_WORDS): index of the fill word.
- `fill_data` out DATA_W: the fill word.
- `done` out 1: one-cycle pulse when the line is complete.
- `err` out 1: one-cycle pulse when the transaction was abandoned on timeout.

## Operation

States: IDLE, WB, RD, FIN, ERR.

- **IDLE**
  - `req_ready` is 1.
  - When `req_valid` is 1, latch the line bases (address AND ~(LINE_WORDS-1)) and `req_dirty`, then clear the word counter.
  - Go to WB if dirty, otherwise RD.
- **WB**
  - Drive `mem_req`=1, `mem_we`=1, `mem_addr`=victim base + counter, and `mem_wdata`=`wb_data`.
  - `wb_idx` equals the counter in every state.
  - On `mem_ack`, increment the counter. After the last word, clear the counter and go to RD.
- **RD**
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=miss base + counter.
  - On `mem_ack`, register `mem_rdata` and the counter into the fill registers, then increment the counter.
  - After the last word, go to FIN.
- **FIN**: assert `done` for one cycle, then go to IDLE.
- **ERR**: assert `err` for one cycle, then go to IDLE. No further memory access and no further fills.
- **Watchdog**
  - The counter clears on every `mem_ack` and on entry to WB or RD.
  - It increments each cycle that `mem_req` is 1 and `mem_ack` is 0.
  - When it reaches `TIMEOUT`, go to ERR, and `mem_req` drops in that same transition.
- **Request/address rules**
  - `mem_req` stays high, and `mem_addr`/`mem_we`/`mem_wdata` stay stable, until `mem_ack`. At most one access is outstanding.
  - Address arithmetic is modulo 2^ADDR_W. A base plus index never carries into the tag, because the base low bits are zero.
- **Ignored inputs**: `mem_ack` while `mem_req` is 0 is ignored. `req_valid` outside IDLE is ignored, because `req_ready` is 0.

## Timing

- **Reset values**: state IDLE, `req_ready`=1, and 0 for `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `fill_valid`, `fill_idx`, `fill_data`, `done`, `err` and `wb_idx`. Reset in any state abandons the transaction immediately.
- **Accept cycle**: `req_ready` and `req_valid` both high at edge N gives `mem_req`=1 from cycle N+1.
- **Fill timing**: `mem_ack` at edge M gives `fill_valid`=1 with the data during cycle M+1, for exactly one cycle.
- **Word pacing**: the next `mem_req` address is presented in cycle M+1, so a back-to-back-ack memory completes one word per cycle.
- **Done**: the last read ack at edge L gives both the last fill and `done` in cycle L+1. `req_ready` returns in cycle L+2.
- **Clean-miss latency**: with zero-wait memory (ack asserted in the first request cycle), a clean miss takes LINE_WORDS+2 cycles from accept to ready. A dirty miss adds LINE_WORDS cycles.

## Structure

- **Shared package `cache_pkg`**: the state enum (IDLE, WB, RD, FIN, ERR), and the `ADDR_W`/`DATA_W`/`LINE_WORDS` defaults also used by `tt_um_cache_controller`.
- **Optional sub-module `refill_watchdog`**: the timeout counter, with inputs `active`, `ack` and `clr`, and output `expired`.
- **Everything else**: one FSM and datapath in `cache_refill_engine`.

## Test plan

Defaults for all scenarios: LINE_WORDS=4 and TIMEOUT=15.

- **Clean miss, zero-wait memory**:
  - Stimulus: `req_addr`=0x0A, `req_dirty`=0, memory returns 0x10 + addr.
  - Required: reads at 0x08, 0x09, 0x0A, 0x0B; fills (0,0x18), (1,0x19), (2,0x1A), (3,0x1B); `done` 1 cycle after the last ack; `req_ready` 6 cycles after accept.
- **Dirty miss**:
  - Stimulus: victim 0x44, `wb_data`=0xA0+`wb_idx`, miss 0x04.
  - Required: writes 0x44..0x47 with data 0xA0..0xA3, strictly before reads 0x04..0x07.
- **Wait states**:
  - Stimulus: ack after 3 idle cycles per word.
  - Required: `mem_addr`/`mem_we`/`mem_wdata` stable while `mem_req` waits; exactly 4 fills; no `err`.
- **Timeout**:
  - Stimulus: memory never acks on read word 2.
  - Required: `err` pulses 15 cycles after that request began; fills for 0 and 1 only; no `done`; `req_ready`=1 next cycle.
- **Reset mid-writeback**:
  - Stimulus: assert `rst` during WB word 1.
  - Required: next cycle all outputs are at reset values, and a new request then completes normally.
- **Stray ack, and req_valid while busy**:
  - Stimulus: `mem_ack` pulse in IDLE, and `req_valid` held high for the whole transaction.
  - Required: the ack has no effect, and the held request is accepted only after `done`.
